// File: rtl/fetch_stage_ifid.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, drives the word-indexed instruction-memory read, and latches
// the fetched word and its PC+4 for decode. It also detects load-use hazards
// against ID/EX and flushes the wrong-path fetch on a taken branch or jump.
module fetch_stage_ifid #(
  parameter logic [31:0] PC_RESET    = 32'h0000_0000,
  parameter int          IMEM_ADDR_W = 10,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0000
) (
  input  logic                   Clk,
  input  logic                   Rst,
  output logic [IMEM_ADDR_W-1:0] IM_Addr,
  input  logic [31:0]            IM_Data,
  input  logic                   Redirect,
  input  logic [31:0]            RedirectTarget,
  input  logic                   ExtStall,
  input  logic                   IDEX_MemRead,
  input  logic [4:0]             IDEX_Rt,
  output logic [31:0]            PC,
  output logic [31:0]            IFID_Instruction,
  output logic [31:0]            IFID_PCPlus4,
  output logic                   IFID_Valid,
  output logic                   HazardStall
);

  logic [5:0]  op;
  logic [4:0]  rs, rt;
  logic        uses_rs, uses_rt;
  logic        stall;
  logic [31:0] pc_plus4;

  assign op = IFID_Instruction[31:26];
  assign rs = IFID_Instruction[25:21];
  assign rt = IFID_Instruction[20:16];

  // Register-usage decode for the instruction sitting in IF/ID.
  always_comb begin
    uses_rs = !(op == 6'b000010 || op == 6'b000011);
    unique case (op)
      6'b000000, 6'b000100, 6'b000101,
      6'b101011, 6'b101000, 6'b101001: uses_rt = 1'b1;
      default:                         uses_rt = 1'b0;
    endcase
  end

  // Load-use hazard. The load target is only live in EX, so a consumer in ID
  // has to wait one cycle. Register $0 and flushed entries never stall.
  assign HazardStall = IFID_Valid && IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                       ((uses_rs && (rs == IDEX_Rt)) || (uses_rt && (rt == IDEX_Rt)));

  assign stall    = HazardStall | ExtStall;
  assign pc_plus4 = PC + 32'd4;
  assign IM_Addr  = PC[IMEM_ADDR_W+1:2];

  // PC and IF/ID update. The priority order is reset, then redirect, then
  // stall, then advance. A redirect squashes the sequential fetch because
  // there is no delay slot.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      PC               <= {PC_RESET[31:2], 2'b00};
      IFID_Instruction <= NOP_INSTR;
      IFID_PCPlus4     <= 32'd0;
      IFID_Valid       <= 1'b0;
    end else if (Redirect) begin
      PC               <= {RedirectTarget[31:2], 2'b00};
      IFID_Instruction <= NOP_INSTR;
      IFID_PCPlus4     <= 32'd0;
      IFID_Valid       <= 1'b0;
    end else if (!stall) begin
      PC               <= pc_plus4;
      IFID_Instruction <= IM_Data;
      IFID_PCPlus4     <= pc_plus4;
      IFID_Valid       <= 1'b1;
    end
  end

endmodule
